// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes,
// ALU operation classes and the bundle of datapath control signals.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXE    = 4'd7,
    R_WB     = 4'd8,
    I_EXE    = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_legal_op(logic [5:0] op);
    return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction

  // States whose exit back to FETCH completes an instruction.
  function automatic logic is_retire_state(state_t s);
    return s inside {MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP};
  endfunction

endpackage

// File: rtl/multicycle_out_dec.sv
// Combinational decode of the current controller state into datapath controls;
// mem_ready and zero are the only Mealy inputs, op only flags illegal opcodes.
module multicycle_out_dec
  import multicycle_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
        illegal        = !is_legal_op(op);
      end
      MEM_ADDR, I_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      R_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      I_WB: ctrl.reg_write = 1'b1;
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = 2'b01;
        ctrl.pc_write  = zero;
      end
      JUMP: begin
        ctrl.pc_source = 2'b10;
        ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: FSM state register, next-state logic and a
// saturating retired-instruction counter; output decode lives in multicycle_out_dec.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  Op_i,
  input  logic        Zero_i,
  input  logic        mem_ready_i,
  output logic        PCWrite_o,
  output logic        IRWrite_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        IorD_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        RegDst_o,
  output logic        ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [1:0]  ALUOp_o,
  output logic [1:0]  PCSource_o,
  output logic        illegal_o,
  output logic [3:0]  state_o,
  output logic [15:0] retire_cnt_o
);

  state_t      state;
  state_t      state_next;
  logic [15:0] retire_cnt;
  logic        retire;
  ctrl_t       ctrl;
  logic        illegal;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      retire_cnt <= '0;
    end else begin
      state <= state_next;
      if (retire && (retire_cnt != 16'hFFFF)) begin
        retire_cnt <= retire_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:     state_next = start_i ? FETCH : IDLE;
      FETCH:    state_next = mem_ready_i ? DECODE : FETCH;
      DECODE: begin
        case (Op_i)
          OP_R:         state_next = R_EXE;
          OP_ADDI:      state_next = I_EXE;
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEM_ADDR: state_next = (Op_i == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   state_next = mem_ready_i ? MEM_WB : MEM_RD;
      MEM_WR:   state_next = mem_ready_i ? FETCH : MEM_WR;
      R_EXE:    state_next = R_WB;
      I_EXE:    state_next = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_next = FETCH;
      default:  state_next = IDLE;
    endcase
  end

  assign retire = (state_next == FETCH) && is_retire_state(state);

  multicycle_out_dec u_out_dec (
    .state     (state),
    .op        (Op_i),
    .mem_ready (mem_ready_i),
    .zero      (Zero_i),
    .ctrl      (ctrl),
    .illegal   (illegal)
  );

  // Write enables stay low while reset is held, even before the first reset edge.
  assign PCWrite_o    = ctrl.pc_write  & rst_i;
  assign IRWrite_o    = ctrl.ir_write  & rst_i;
  assign MemWrite_o   = ctrl.mem_write & rst_i;
  assign RegWrite_o   = ctrl.reg_write & rst_i;
  assign illegal_o    = illegal        & rst_i;
  assign MemRead_o    = ctrl.mem_read;
  assign IorD_o       = ctrl.iord;
  assign MemtoReg_o   = ctrl.mem_to_reg;
  assign RegDst_o     = ctrl.reg_dst;
  assign ALUSrcA_o    = ctrl.alu_src_a;
  assign ALUSrcB_o    = ctrl.alu_src_b;
  assign ALUOp_o      = ctrl.alu_op;
  assign PCSource_o   = ctrl.pc_source;
  assign state_o      = state;
  assign retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instructions are expanded into
// per-cycle step lists and every cycle is compared against the expected outputs.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  Op_i = '0;
  logic        Zero_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic        PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, IorD_o;
  logic        RegWrite_o, MemtoReg_o, RegDst_o, ALUSrcA_o, illegal_o;
  logic [1:0]  ALUSrcB_o, ALUOp_o, PCSource_o;
  logic [3:0]  state_o;
  logic [15:0] retire_cnt_o;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
    S_MADDR = 4'd3, S_MRD = 4'd4, S_MWB = 4'd5, S_MWR = 4'd6, S_REXE = 4'd7,
    S_RWB = 4'd8, S_IEXE = 4'd9, S_IWB = 4'd10, S_BRANCH = 4'd11, S_JUMP = 4'd12;

  localparam logic [5:0] OPC_R = 6'b000000, OPC_ADDI = 6'b001000,
    OPC_LW = 6'b100011, OPC_SW = 6'b101011, OPC_BEQ = 6'b000100, OPC_J = 6'b000010;

  typedef struct packed {
    logic pcw, irw, mrd, mwr, iord, rw, m2r, rdst, asa;
    logic [1:0] asb, aop, pcs;
    logic ill;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       c;
  } tr_t;

  ctl_t act_ctl;
  ctl_t exp_ctl = '0;
  logic [3:0] exp_state = S_IDLE;
  int   exp_cnt = 0;
  bit   chk_en = 1'b0;
  bit   rand_dc = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   retired = 0;
  tr_t  trace[$];
  int   lat_cnt = 0;
  int   last_lat = 0;
  logic [3:0] prev_st = S_IDLE;

  multicycle_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .Op_i         (Op_i),
    .Zero_i       (Zero_i),
    .mem_ready_i  (mem_ready_i),
    .PCWrite_o    (PCWrite_o),
    .IRWrite_o    (IRWrite_o),
    .MemRead_o    (MemRead_o),
    .MemWrite_o   (MemWrite_o),
    .IorD_o       (IorD_o),
    .RegWrite_o   (RegWrite_o),
    .MemtoReg_o   (MemtoReg_o),
    .RegDst_o     (RegDst_o),
    .ALUSrcA_o    (ALUSrcA_o),
    .ALUSrcB_o    (ALUSrcB_o),
    .ALUOp_o      (ALUOp_o),
    .PCSource_o   (PCSource_o),
    .illegal_o    (illegal_o),
    .state_o      (state_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign act_ctl = {PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, IorD_o, RegWrite_o,
                    MemtoReg_o, RegDst_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o,
                    illegal_o};

  function automatic bit legal(logic [5:0] op);
    return op inside {OPC_R, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_J};
  endfunction

  // Control values each state must present, taken from the state/output table.
  function automatic ctl_t model_ctl(logic [3:0] st, bit rdy, bit z, logic [5:0] op, bit rst);
    ctl_t e;
    e = '0;
    case (st)
      S_FETCH:  begin e.mrd = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      S_DECODE: begin e.asb = 2'b11; e.ill = !legal(op); end
      S_MADDR, S_IEXE: begin e.asa = 1; e.asb = 2'b10; end
      S_MRD:    begin e.mrd = 1; e.iord = 1; end
      S_MWR:    begin e.mwr = 1; e.iord = 1; end
      S_MWB:    begin e.rw = 1; e.m2r = 1; end
      S_REXE:   begin e.asa = 1; e.aop = 2'b10; end
      S_RWB:    begin e.rw = 1; e.rdst = 1; end
      S_IWB:    e.rw = 1;
      S_BRANCH: begin e.asa = 1; e.aop = 2'b01; e.pcs = 2'b01; e.pcw = z; end
      S_JUMP:   begin e.pcs = 2'b10; e.pcw = 1; end
      default: ;
    endcase
    if (!rst) begin
      e.pcw = 0; e.irw = 0; e.mwr = 0; e.rw = 0; e.ill = 0;
    end
    return e;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit dcr();
    return rand_dc ? rb() : 1'b1;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = OPC_R;
      1: op = OPC_ADDI;
      2: op = OPC_LW;
      3: op = OPC_SW;
      4: op = OPC_BEQ;
      5: op = OPC_J;
      default: begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, publish what the model expects for this cycle.
  task automatic applyStimulus(input bit rst, input logic [3:0] st, input bit rdy,
                               input bit z, input logic [5:0] op, input bit start);
    @(posedge clk_i);
    #1;
    rst_i = rst; start_i = start; mem_ready_i = rdy; Zero_i = z; Op_i = op;
    exp_state = st;
    exp_ctl   = model_ctl(st, rdy, z, op, rst);
    exp_cnt   = (retired > 65535) ? 65535 : retired;
    chk_en    = 1'b1;
    @(negedge clk_i);
    #1;
    if (!rst) retired = 0;
  endtask

  // Expand one instruction into its cycle sequence, starting in FETCH.
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw, input bit z);
    for (int i = 0; i < fw; i++) applyStimulus(1, S_FETCH, 0, rb(), 6'($urandom), rb());
    applyStimulus(1, S_FETCH, 1, rb(), 6'($urandom), rb());
    applyStimulus(1, S_DECODE, dcr(), rb(), op, rb());
    if (op == OPC_R) begin
      applyStimulus(1, S_REXE, dcr(), rb(), op, rb());
      applyStimulus(1, S_RWB, dcr(), rb(), op, rb());
      retired++;
    end else if (op == OPC_ADDI) begin
      applyStimulus(1, S_IEXE, dcr(), rb(), op, rb());
      applyStimulus(1, S_IWB, dcr(), rb(), op, rb());
      retired++;
    end else if (op == OPC_LW) begin
      applyStimulus(1, S_MADDR, dcr(), rb(), op, rb());
      for (int i = 0; i < mw; i++) applyStimulus(1, S_MRD, 0, rb(), op, rb());
      applyStimulus(1, S_MRD, 1, rb(), op, rb());
      applyStimulus(1, S_MWB, dcr(), rb(), op, rb());
      retired++;
    end else if (op == OPC_SW) begin
      applyStimulus(1, S_MADDR, dcr(), rb(), op, rb());
      for (int i = 0; i < mw; i++) applyStimulus(1, S_MWR, 0, rb(), op, rb());
      applyStimulus(1, S_MWR, 1, rb(), op, rb());
      retired++;
    end else if (op == OPC_BEQ) begin
      applyStimulus(1, S_BRANCH, dcr(), z, op, rb());
      retired++;
    end else if (op == OPC_J) begin
      applyStimulus(1, S_JUMP, dcr(), rb(), op, rb());
      retired++;
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      checkOutput("state", int'(state_o), int'(exp_state));
      checkOutput("ctrl", int'(act_ctl), int'(exp_ctl));
      checkOutput("retire_cnt", int'(retire_cnt_o), exp_cnt);
    end
  end

  // Observed trace and FETCH-to-FETCH latency, measured on the DUT outputs.
  always @(negedge clk_i) begin
    if (chk_en) trace.push_back({state_o, act_ctl});
    if (state_o == S_FETCH && prev_st != S_FETCH && prev_st != S_IDLE) last_lat = lat_cnt;
    if (state_o == S_FETCH && mem_ready_i) lat_cnt = 1;
    else lat_cnt++;
    prev_st = state_o;
  end

  initial begin
    logic [3:0] want_r[6];
    int n;
    bit seen;
    want_r = '{S_IDLE, S_FETCH, S_DECODE, S_REXE, S_RWB, S_FETCH};

    repeat (2) @(posedge clk_i);
    for (int i = 0; i < 3; i++) applyStimulus(0, S_IDLE, rb(), rb(), 6'($urandom), rb());
    checkOutput("reset_state", int'(state_o), 0);
    checkOutput("reset_cnt", int'(retire_cnt_o), 0);
    checkOutput("reset_ctl", int'(act_ctl), 0);
    for (int i = 0; i < 2; i++) applyStimulus(1, S_IDLE, rb(), rb(), 6'($urandom), 0);

    rand_dc = 1'b0;
    trace.delete();
    applyStimulus(1, S_IDLE, 1, 0, OPC_R, 1);
    runInstr(OPC_R, 0, 0, 0);
    applyStimulus(1, S_FETCH, 0, 0, OPC_R, 0);
    rand_dc = 1'b1;
    checkOutput("r_trace_len", trace.size(), 6);
    if (trace.size() >= 6) begin
      for (int i = 0; i < 6; i++) checkOutput("r_trace_state", int'(trace[i].st), int'(want_r[i]));
      checkOutput("r_wb_regwrite_regdst", int'({trace[4].c.rw, trace[4].c.rdst}), 3);
    end
    checkOutput("r_retire", int'(retire_cnt_o), 1);

    trace.delete();
    runInstr(OPC_LW, 0, 3, 0);
    applyStimulus(1, S_FETCH, 0, 0, 6'($urandom), 0);
    n = 0;
    seen = 1'b0;
    foreach (trace[i]) begin
      if (trace[i].st == S_MRD && trace[i].c.mrd) n++;
      if (trace[i].st == S_MWB && trace[i].c.m2r) seen = 1'b1;
    end
    checkOutput("lw_memread_cycles", n, 4);
    checkOutput("lw_memtoreg", int'(seen), 1);
    checkOutput("lw_latency", last_lat, 8);
    checkOutput("lw_retire", int'(retire_cnt_o), 2);

    trace.delete();
    runInstr(OPC_BEQ, 0, 0, 1);
    runInstr(OPC_BEQ, 0, 0, 0);
    applyStimulus(1, S_FETCH, 0, 0, 6'($urandom), 0);
    n = 0;
    foreach (trace[i]) begin
      if (trace[i].st == S_BRANCH) begin
        checkOutput(n == 0 ? "beq_taken" : "beq_not_taken",
                    int'({trace[i].c.pcw, trace[i].c.pcs}), n == 0 ? 5 : 1);
        n++;
      end
    end
    checkOutput("beq_count", n, 2);
    checkOutput("beq_retire", int'(retire_cnt_o), 4);

    trace.delete();
    runInstr(6'b111111, 0, 0, 0);
    applyStimulus(1, S_FETCH, 0, 0, 6'($urandom), 0);
    n = 0;
    foreach (trace[i]) if (trace[i].c.ill) n++;
    checkOutput("illegal_pulses", n, 1);
    if (trace.size() >= 3) checkOutput("illegal_next_state", int'(trace[2].st), 1);
    checkOutput("illegal_retire", int'(retire_cnt_o), 4);

    applyStimulus(1, S_FETCH, 1, 0, 6'($urandom), 0);
    applyStimulus(1, S_DECODE, 1, 0, OPC_SW, 0);
    applyStimulus(1, S_MADDR, 0, 0, OPC_SW, 0);
    applyStimulus(1, S_MWR, 0, 0, OPC_SW, 0);
    applyStimulus(0, S_MWR, 0, 0, OPC_SW, 0);
    applyStimulus(1, S_IDLE, 0, 0, OPC_SW, 0);
    checkOutput("sw_reset_state", int'(state_o), 0);
    checkOutput("sw_reset_memwrite", int'(MemWrite_o), 0);
    checkOutput("sw_reset_cnt", int'(retire_cnt_o), 0);

    applyStimulus(1, S_IDLE, 0, 0, 6'($urandom), 1);
    for (int k = 0; k < 250; k++)
      runInstr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3), rb());

    // Counting to 0xFFFF by execution would take ~200k cycles, so preload near the top.
    applyStimulus(0, S_FETCH, rb(), rb(), 6'($urandom), rb());
    force dut.retire_cnt = 16'hFFFD;
    retired = 65533;
    applyStimulus(1, S_IDLE, 0, 0, 6'($urandom), 0);
    release dut.retire_cnt;
    applyStimulus(1, S_IDLE, 0, 0, 6'($urandom), 1);
    for (int k = 0; k < 3; k++) runInstr(OPC_J, 0, 0, 0);
    applyStimulus(1, S_FETCH, 0, 0, 6'($urandom), 0);
    checkOutput("sat_cnt", int'(retire_cnt_o), 16'hFFFF);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
